// File: rtl/stack_unit.sv
// LIFO operand stack fed by the stack-machine controller's push/pop/tos/mtos strobes.
// Optional macro STACK_ERR_CLR_EN adds an err_clr input that clears the sticky flags.
module stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned SPW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             mtos,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_data,
`ifdef STACK_ERR_CLR_EN
    input  logic             err_clr,
`endif
    output logic [WIDTH-1:0] stack_out,
    output logic [SPW-1:0]   sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [SPW-1:0]   sp_q, sp_d, sp_minus;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             we;
    logic [SPW-2:0]   waddr, top_idx;
    logic [WIDTH-1:0] push_data;

    assign push_data = mtos ? mem_data : alu_data;
    assign sp_minus  = sp_q - SPW'(1);
    assign top_idx   = sp_minus[SPW-2:0];

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SPW'(DEPTH));
    assign sp        = sp_q;
    assign stack_out = out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        sp_d  = sp_q;
        out_d = out_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        we    = 1'b0;
        waddr = sp_q[SPW-2:0];
`ifdef STACK_ERR_CLR_EN
        // A fresh error below re-sets the flag, so it wins over the clear.
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
`endif
        if (push && pop) begin
            if (!empty) begin
                out_d = mem[top_idx];
                we    = 1'b1;
                waddr = top_idx;
            end else begin
                // Nothing to replace: degrade to a plain push, flag the bad pop.
                we    = 1'b1;
                sp_d  = sp_q + SPW'(1);
                unf_d = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                we   = 1'b1;
                sp_d = sp_q + SPW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                out_d = mem[top_idx];
                sp_d  = sp_minus;
            end else begin
                unf_d = 1'b1;
            end
        end else if (tos) begin
            if (!empty) begin
                out_d = mem[top_idx];
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Array is deliberately not cleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= push_data;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (DEPTH=4): queue-based reference stack plus
// a scoreboard of expected stack_out values produced by pop/tos.
module tb_stack_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPW   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst, push, pop, tos, mtos, err_clr;
    logic [WIDTH-1:0] mem_data, alu_data;
    logic [WIDTH-1:0] stack_out;
    logic [SPW-1:0]   sp;
    logic             empty, full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] m_out;
    logic             m_ovf, m_unf;

    always #5 clk = ~clk;

    stack_unit #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .tos      (tos),
        .mtos     (mtos),
        .mem_data (mem_data),
        .alu_data (alu_data),
`ifdef STACK_ERR_CLR_EN
        .err_clr  (err_clr),
`endif
        .stack_out(stack_out),
        .sp       (sp),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " sp"}, 32'(sp), 32'(model.size()));
        check({tag, " empty"}, 32'(empty), 32'(model.size() == 0));
        check({tag, " full"}, 32'(full), 32'(model.size() == DEPTH));
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
        if (sb.size() != 0) m_out = sb.pop_front();
        check({tag, " stack_out"}, 32'(stack_out), 32'(m_out));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; mtos = 1'b0;
        err_clr = 1'b0; mem_data = '0; alu_data = '0;
    endtask

    // One clock of stimulus; the reference model is updated from the spec rules.
    task automatic step(input string tag, input logic p, input logic po, input logic t,
                        input logic m, input logic [WIDTH-1:0] md,
                        input logic [WIDTH-1:0] ad);
        logic [WIDTH-1:0] d;
        d = m ? md : ad;
        push = p; pop = po; tos = t; mtos = m; mem_data = md; alu_data = ad;
`ifdef STACK_ERR_CLR_EN
        if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
`endif
        if (p && po) begin
            if (model.size() != 0) begin
                sb.push_back(model[model.size() - 1]);
                model[model.size() - 1] = d;
            end else begin
                model.push_back(d);
                m_unf = 1'b1;
            end
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (model.size() != 0) sb.push_back(model.pop_back());
            else m_unf = 1'b1;
        end else if (t) begin
            if (model.size() != 0) sb.push_back(model[model.size() - 1]);
            else m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic with_push);
        rst = 1'b1; push = with_push; alu_data = 8'hEE;
        model.delete(); sb.delete();
        m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        compare_all(tag);
    endtask

    initial begin
        idle_inputs();
        m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
        do_reset("reset", 1'b0);

        // Basic push from both sources, then pops.
        step("push_alu", 1, 0, 0, 0, 8'h00, 8'h11);
        step("push_mem", 1, 0, 0, 1, 8'h22, 8'h00);
        step("pop1", 0, 1, 0, 0, 8'h00, 8'h00);
        check("pop1 value", 32'(stack_out), 32'h22);
        step("pop2", 0, 1, 0, 0, 8'h00, 8'h00);
        check("pop2 value", 32'(stack_out), 32'h11);

        // Pop while empty: stack_out holds 0x11.
        step("pop_empty", 0, 1, 0, 0, 8'h00, 8'h00);
        check("pop_empty hold", 32'(stack_out), 32'h11);
        step("push_33", 1, 0, 0, 0, 8'h00, 8'h33);
        step("pop_33", 0, 1, 0, 0, 8'h00, 8'h00);

        // tos does not consume.
        step("push_5a", 1, 0, 0, 0, 8'h00, 8'h5A);
        step("tos1", 0, 0, 1, 0, 8'h00, 8'h00);
        check("tos1 value", 32'(stack_out), 32'h5A);
        step("tos2", 0, 0, 1, 0, 8'h00, 8'h00);
        step("pop_5a", 0, 1, 0, 0, 8'h00, 8'h00);
        step("tos_empty", 0, 0, 1, 0, 8'h00, 8'h00);

        // Fill, overflow, drain.
        do_reset("reset2", 1'b0);
        for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, i[0], 8'(i), 8'(i));
        step("push_full", 1, 0, 0, 0, 8'h00, 8'h05);
        for (int i = 4; i >= 1; i--) begin
            step("drain", 0, 1, 0, 0, 8'h00, 8'h00);
            check("drain value", 32'(stack_out), 32'(i));
        end

        // Replace-top and tos ignored alongside pop/push.
        do_reset("reset3", 1'b0);
        step("push_10", 1, 0, 0, 0, 8'h00, 8'h10);
        step("push_20", 1, 0, 0, 0, 8'h00, 8'h20);
        step("replace", 1, 1, 1, 0, 8'h00, 8'h99);
        check("replace value", 32'(stack_out), 32'h20);
        step("pop_99", 0, 1, 1, 0, 8'h00, 8'h00);
        check("pop_99 value", 32'(stack_out), 32'h99);
        step("pop_10", 0, 1, 0, 0, 8'h00, 8'h00);
        step("replace_empty", 1, 1, 0, 1, 8'h44, 8'h00);
        step("pop_44", 0, 1, 0, 0, 8'h00, 8'h00);

        // Reset during a push with 3 entries and overflow set.
        do_reset("reset4", 1'b0);
        for (int i = 0; i < 5; i++) step("fill2", 1, 0, 0, 0, 8'h00, 8'(8'hA0 + i));
        step("pop_a3", 0, 1, 0, 0, 8'h00, 8'h00);
        do_reset("reset_push", 1'b1);
        step("tos_after_rst", 0, 0, 1, 0, 8'h00, 8'h00);

`ifdef STACK_ERR_CLR_EN
        step("push_77", 1, 0, 0, 0, 8'h00, 8'h77);
        step("pop_77", 0, 1, 0, 0, 8'h00, 8'h00);
        step("push_66", 1, 0, 0, 0, 8'h00, 8'h66);
        err_clr = 1'b1;
        step("err_clr", 0, 0, 0, 0, 8'h00, 8'h00);
        step("pop_66", 0, 1, 0, 0, 8'h00, 8'h00);
        err_clr = 1'b1;
        step("clr_vs_err", 0, 1, 0, 0, 8'h00, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
